// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler that time-shares one echo-timing datapath across N ultrasonic sensors.
// Each slot: trigger pulse, wait for echo rise, time the echo, write a scaled distance, quiet gap.
module ultrasonic_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 3000000,
    parameter int COUNT_SHIFT    = 8,
    parameter int DIST_W         = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_SENSORS-1:0]           echo,
    output logic [N_SENSORS-1:0]           trig,
    output logic [N_SENSORS*DIST_W-1:0]    distance,
    output logic                           dist_valid,
    output logic [$clog2(N_SENSORS)-1:0]   dist_sensor,
    output logic [N_SENSORS-1:0]           timeout,
    output logic                           busy,
    output logic [2:0]                     fsm_state
);

    localparam int IDX_W  = $clog2(N_SENSORS);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = TMO_W;
    localparam int PH_MAX = (GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RES_W  = (CNT_W > DIST_W) ? CNT_W : DIST_W;

    localparam logic [DIST_W-1:0] MAX_VALID = {{(DIST_W-1){1'b1}}, 1'b0};
    localparam logic [DIST_W-1:0] TMO_CODE  = {DIST_W{1'b1}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [PH_W-1:0]      phase_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [CNT_W-1:0]     echo_cnt;
    logic [N_SENSORS-1:0] echo_s1;
    logic [N_SENSORS-1:0] echo_s2;
    logic [N_SENSORS-1:0] echo_prev;

    logic              echo_sel;
    logic              echo_rise;
    logic              tmo_last;
    logic              do_write;
    logic              write_tmo;
    logic [RES_W-1:0]  shifted;
    logic [DIST_W-1:0] res_val;
    logic [IDX_W-1:0]  idx_next;

    always_comb begin
        echo_sel  = echo_s2[idx];
        echo_rise = echo_s2[idx] & ~echo_prev[idx];
        tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        shifted   = RES_W'(echo_cnt) >> COUNT_SHIFT;
        res_val   = (shifted > RES_W'(MAX_VALID)) ? MAX_VALID : shifted[DIST_W-1:0];
        idx_next  = (idx == IDX_W'(N_SENSORS - 1)) ? '0 : idx + 1'b1;

        // A falling edge on the deadline cycle still yields a valid result.
        do_write  = 1'b0;
        write_tmo = 1'b0;
        if (state == S_WAIT && tmo_last) begin
            do_write  = 1'b1;
            write_tmo = 1'b1;
        end
        if (state == S_MEAS) begin
            if (!echo_sel) begin
                do_write = 1'b1;
            end else if (tmo_last) begin
                do_write  = 1'b1;
                write_tmo = 1'b1;
            end
        end

        trig = '0;
        if (state == S_TRIG) trig[idx] = 1'b1;
        busy      = (state != S_IDLE);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            phase_cnt   <= '0;
            tmo_cnt     <= '0;
            echo_cnt    <= '0;
            echo_s1     <= '0;
            echo_s2     <= '0;
            echo_prev   <= '0;
            distance    <= '0;
            dist_valid  <= 1'b0;
            dist_sensor <= '0;
            timeout     <= '0;
        end else begin
            echo_s1    <= echo;
            echo_s2    <= echo_s1;
            echo_prev  <= echo_s2;
            dist_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_TRIG;
                        phase_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (phase_cnt == PH_W'(TRIG_CYCLES - 1)) begin
                        state     <= S_WAIT;
                        phase_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Echo already high on entry has no rising edge, so it is ignored.
                    if (!do_write && echo_rise) begin
                        state    <= S_MEAS;
                        echo_cnt <= CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (echo_sel) echo_cnt <= echo_cnt + 1'b1;
                end
                S_GAP: begin
                    if (phase_cnt == PH_W'(GAP_CYCLES - 1)) begin
                        phase_cnt <= '0;
                        idx       <= idx_next;
                        state     <= enable ? S_TRIG : S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (do_write) begin
                state     <= S_GAP;
                phase_cnt <= '0;
                distance[idx*DIST_W +: DIST_W] <= write_tmo ? TMO_CODE : res_val;
                timeout[idx] <= write_tmo;
                dist_valid   <= 1'b1;
                dist_sensor  <= idx;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler: table of per-slot echo scenarios, a result scoreboard,
// and hand-written sequences for reset-in-trigger and enable dropping mid-measurement.
module tb_ultrasonic_scheduler;

    localparam int N     = 4;
    localparam int TRIGC = 4;
    localparam int TMO   = 2000;
    localparam int GAP   = 16;
    localparam int SHIFT = 2;
    localparam int DW    = 16;
    localparam int W     = 2 + DW + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    echo;
    logic [N-1:0]    trig;
    logic [N*DW-1:0] distance;
    logic            dist_valid;
    logic [1:0]      dist_sensor;
    logic [N-1:0]    timeout;
    logic            busy;
    logic [2:0]      fsm_state;

    ultrasonic_scheduler #(
        .N_SENSORS(N), .TRIG_CYCLES(TRIGC), .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES(GAP), .COUNT_SHIFT(SHIFT), .DIST_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
        .distance(distance), .dist_valid(dist_valid), .dist_sensor(dist_sensor),
        .timeout(timeout), .busy(busy), .fsm_state(fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // scoreboard: {sensor, distance, timeout flag}
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    e;
    logic [DW-1:0]   bank[N];
    logic [N-1:0]    tmo_m;
    logic [N*DW-1:0] flat;
    int              last_valid_cyc = 0;

    initial begin
        for (int i = 0; i < N; i++) bank[i] = '0;
        tmo_m = '0;
    end

    always @(negedge clk) begin
        if (dist_valid) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_valid: dist_valid with sensor %0d, no result expected", dist_sensor);
            end else begin
                e = exp_q.pop_front();
                bank[e[W-1:W-2]]  = e[DW:1];
                tmo_m[e[W-1:W-2]] = e[0];
                for (int i = 0; i < N; i++) flat[i*DW +: DW] = bank[i];
                check("dist_sensor", dist_sensor, e[W-1:W-2]);
                check("distance_bank", distance, flat);
                check("timeout_flags", timeout, tmo_m);
            end
            last_valid_cyc = cyc;
        end
    end

    typedef struct {
        int            sensor;
        int            high;
        bit            stale;
        bit            drop_en;
        logic [DW-1:0] exp_dist;
        bit            exp_tmo;
    } vec_t;

    vec_t vecs[8];

    // driver: one measurement slot
    task automatic do_slot(input vec_t v, input bit check_gap);
        int n;
        int tcnt;
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[v.sensor] = 1'b1;
        exp_q.push_back({2'(v.sensor), v.exp_dist, v.exp_tmo});
        if (v.stale) echo[v.sensor] = 1'b1;

        n = 0;
        while (trig == '0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            check("trig_wait_expired", 1'b1, 1'b0 ^ (n < 5000));
            return;
        end
        check("trig_select", trig, onehot);
        if (check_gap) check("gap_cycles", cyc - last_valid_cyc, GAP);

        tcnt = 0;
        while (trig != '0 && tcnt < 20) begin
            tcnt++;
            if (tcnt == 3 && v.high > 0) echo[v.sensor] = 1'b1;
            @(negedge clk);
        end
        check("trig_len", tcnt, TRIGC);

        if (v.high > 0) begin
            if (v.drop_en) begin
                repeat ((v.high - 2) / 2) @(negedge clk);
                enable = 1'b0;
                repeat (v.high - 2 - (v.high - 2) / 2) @(negedge clk);
            end else begin
                repeat (v.high - 2) @(negedge clk);
            end
            echo[v.sensor] = 1'b0;
        end

        if (v.stale) begin
            n = 0;
            while (!dist_valid && n < 2200) begin
                echo[(v.sensor + 1) % N] = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            echo = '0;
            if (n >= 2200) begin
                chk_cnt++;
                $display("FAIL stale_result_wait: no dist_valid within %0d cycles", n);
            end
        end
    endtask

    initial begin
        int h;
        int n;
        int bad;

        vecs[0] = '{0, 400,  1'b0, 1'b0, 16'd100,  1'b0};
        vecs[1] = '{1, 0,    1'b0, 1'b0, 16'hFFFF, 1'b1};
        vecs[2] = '{2, 0,    1'b1, 1'b0, 16'hFFFF, 1'b1};
        h = $urandom_range(2, 1000);
        vecs[3] = '{3, h,    1'b0, 1'b0, DW'(h >> SHIFT), 1'b0};
        vecs[4] = '{0, 1999, 1'b0, 1'b0, 16'd499,  1'b0};
        vecs[5] = '{1, 40,   1'b0, 1'b0, 16'd10,   1'b0};
        vecs[6] = '{2, 2,    1'b0, 1'b0, 16'd0,    1'b0};
        vecs[7] = '{3, 300,  1'b0, 1'b1, 16'd75,   1'b0};

        // reset values
        reset = 1'b0; enable = 1'b0; echo = '0;
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_distance", distance, 0);
        check("rst_dist_valid", dist_valid, 0);
        check("rst_dist_sensor", dist_sensor, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);

        // reset landing mid-trigger
        reset = 1'b1; enable = 1'b1;
        n = 0;
        while (trig == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_trig0", trig, 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midtrig_rst_trig", trig, 0);
        check("midtrig_rst_busy", busy, 0);
        check("midtrig_rst_state", fsm_state, 0);
        check("midtrig_rst_valid", dist_valid, 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) do_slot(vecs[i], i > 0);

        // enable dropped during sensor 3's measurement: finish, gap, then idle at sensor 0
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drop_busy_low", busy, 0);
        check("drop_state_idle", fsm_state, 0);
        check("drop_gap_len", cyc - last_valid_cyc, GAP);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (trig != '0 || busy) bad++;
        end
        check("idle_hold_quiet", bad, 0);
        enable = 1'b1;
        @(negedge clk);
        check("restart_trig0", trig, 4'b0001);
        check("restart_busy", busy, 1);

        // reset clears a populated bank
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("final_rst_trig", trig, 0);
        check("final_rst_distance", distance, 0);
        check("final_rst_timeout", timeout, 0);
        check("final_rst_sensor", dist_sensor, 0);
        check("final_rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        check("results_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
Round-robin controller that shares one echo-timing datapath between N ultrasonic ranging sensors. For each sensor in turn it issues a trigger pulse, waits for the echo, measures the echo high time in clock cycles, and converts it to a scaled distance. It enforces a per-measurement timeout and an inter-ping quiet gap so echoes from one sensor do not corrupt the next. Results go into a per-sensor distance register bank that feeds the downstream averaging and display logic.

Parameters:
N_SENSORS, 4, number of sensors; 2..8
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max cycles from trigger end to echo fall (30 ms)
GAP_CYCLES, 3000000, quiet cycles after each measurement before next trigger
COUNT_SHIFT, 8, right shift applied to echo cycle count to form distance
DIST_W, 16, distance width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
enable  in  1  1 = run scheduling; 0 = stop after current measurement
echo  in  N_SENSORS  raw asynchronous echo inputs
trig  out  N_SENSORS  trigger outputs, at most one high
distance  out  N_SENSORS*DIST_W  flat bank, sensor i at [i*DIST_W +: DIST_W]
dist_valid  out  1  one-cycle pulse: a bank entry was just written
dist_sensor  out  $clog2(N_SENSORS)  index written with dist_valid
timeout  out  N_SENSORS  sticky per-sensor flag: last measurement timed out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, sensor index 0, trig=0, distance all 0, dist_valid=0, dist_sensor=0, timeout=0, busy=0, counters 0, echo synchronizers 0. Applies mid-operation; trig falls at that edge.
- Echo inputs pass a 2-flop synchronizer plus a previous-value flop; all edge detection uses synced values (2-cycle input latency).
- States: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE: if enable=1, go to TRIG for current index.
- TRIG: trig[idx]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE; timeout counter cleared.
- WAIT_RISE: timeout counter increments each cycle. Synced rising edge on echo[idx] -> MEASURE with echo count=1. Echo already high on entry is not a rise; it must fall and rise again or time out.
- MEASURE: echo count increments each cycle synced echo=1; timeout counter keeps running. First cycle synced echo=0 -> latch result, go GAP.
- Result: value = count >> COUNT_SHIFT, saturated to 2^DIST_W-2. Count register wide enough to hold TIMEOUT_CYCLES without wrap.
- Timeout: timeout counter reaching TIMEOUT_CYCLES in WAIT_RISE or MEASURE -> distance[idx]=all ones (2^DIST_W-1), timeout[idx]=1, go GAP.
- Valid result: distance[idx]=value, timeout[idx]=0.
- Result write: dist_valid=1 and dist_sensor=idx in the cycle after the decision cycle (registered), for exactly one cycle. Bank entry visible the same cycle.
- Falling edge and timeout in the same cycle: falling edge wins (valid result).
- GAP: count GAP_CYCLES, then advance idx (wraps N_SENSORS-1 -> 0). If enable=1 go TRIG; otherwise IDLE with advanced idx.
- enable falling mid-measurement does not abort it; the measurement and its gap complete. enable rising in IDLE starts TRIG on the next cycle.
- Echo activity on non-selected sensors is ignored.

Test Plan:
(Params: N_SENSORS=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=2000, GAP_CYCLES=16, COUNT_SHIFT=2.)
1. Reset mid-TRIG: reset=0 while trig[0]=1 -> trig=0 on that edge; all outputs at reset values; busy=0.
2. Sensor 0, echo high 400 synced cycles -> trig[0] high exactly 4 cycles; distance[0]=100; one dist_valid with dist_sensor=0; timeout[0]=0; next trig is trig[1] after 16 gap cycles.
3. Sensor 1, no echo -> after 2000 cycles distance[1]=0xFFFF, timeout[1]=1, dist_valid with dist_sensor=1. A later 40-cycle echo on sensor 1 -> distance[1]=10 and timeout[1] cleared.
4. Echo held high before trigger on sensor 2 -> no measurement from the stale level; timeout result 0xFFFF. Same run: echo toggling on sensor 3 during sensor 2's slot -> distance[3] unchanged.
5. Falling edge landing on the timeout cycle -> valid result 1999>>2=499, timeout flag 0.
6. enable=0 during MEASURE on sensor 3 -> result written, gap completes, state IDLE, idx=0, busy=0. No trig until enable=1; then trig[0] starts the next cycle.
